// File: rtl/nexys_starship_pkg.sv
// Shared Nexys Starship constants: shield FSM one-hot codes, direction indices
// and default tick timing used by the shield controller and the monster terminals.
package nexys_starship_pkg;

  localparam logic [3:0] SH_INIT   = 4'b0001;
  localparam logic [3:0] SH_READY  = 4'b0010;
  localparam logic [3:0] SH_ACTIVE = 4'b0100;
  localparam logic [3:0] SH_COOL   = 4'b1000;

  localparam int DIR_L = 0;
  localparam int DIR_R = 1;
  localparam int DIR_U = 2;
  localparam int DIR_D = 3;

  localparam int DEF_MAX_ENERGY     = 4;
  localparam int DEF_SHIELD_TICKS   = 3;
  localparam int DEF_COOLDOWN_TICKS = 2;
  localparam int DEF_RECHARGE_TICKS = 8;

  // One-hot winner among simultaneous presses, priority L > R > U > D.
  function automatic logic [3:0] pick_dir(input logic [3:0] btn);
    pick_dir = '0;
    if      (btn[DIR_L]) pick_dir[DIR_L] = 1'b1;
    else if (btn[DIR_R]) pick_dir[DIR_R] = 1'b1;
    else if (btn[DIR_U]) pick_dir[DIR_U] = 1'b1;
    else if (btn[DIR_D]) pick_dir[DIR_D] = 1'b1;
  endfunction

endpackage

// File: rtl/nexys_starship_tick_counter.sv
// Loadable down-counter clocked by game ticks; zero_pulse flags the tick that
// takes it from 1 to 0 so the owner can act on the same edge.
module nexys_starship_tick_counter #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero_pulse
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset)                     r_cnt <= '0;
    else if (load)                 r_cnt <= load_val;
    else if (tick && r_cnt != '0)  r_cnt <= r_cnt - W'(1);
  end

  assign zero_pulse = tick && !load && (r_cnt == W'(1));

endmodule

// File: rtl/nexys_starship_shield_ctrl.sv
// Shield controller: button pulses -> one directional shield, rate-limited by
// energy, hold time and cooldown. Define SHIELD_AUTO_RECHARGE_EN for tick recharge.
module nexys_starship_shield_ctrl
  import nexys_starship_pkg::*;
#(
  parameter int MAX_ENERGY     = DEF_MAX_ENERGY,
  parameter int ENERGY_W       = 3,
  parameter int SHIELD_TICKS   = DEF_SHIELD_TICKS,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
  parameter int RECHARGE_TICKS = DEF_RECHARGE_TICKS
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                timer_tick,
  input  logic                play_flag,
  input  logic                gameover_ctrl,
  input  logic                btn_l,
  input  logic                btn_r,
  input  logic                btn_u,
  input  logic                btn_d,
  output logic                left_shield,
  output logic                right_shield,
  output logic                top_shield,
  output logic                btm_shield,
  output logic [ENERGY_W-1:0] shield_energy,
  output logic                q_SH_Init,
  output logic                q_SH_Ready,
  output logic                q_SH_Active,
  output logic                q_SH_Cool
);

  localparam int HOLD_W = $clog2(SHIELD_TICKS + 1);
  localparam int COOL_W = $clog2(COOLDOWN_TICKS + 1);
  localparam logic [ENERGY_W-1:0] E_MAX = ENERGY_W'(MAX_ENERGY);

  logic [3:0]          r_state;
  logic [3:0]          r_shield;
  logic [ENERGY_W-1:0] r_energy;

  logic       w_in_ready, w_in_active, w_in_cool;
  logic [3:0] w_btn, w_win;
  logic       w_accept, w_clear, w_hold_zero, w_cool_zero, w_recharge;

  assign w_in_ready  = (r_state == SH_READY);
  assign w_in_active = (r_state == SH_ACTIVE);
  assign w_in_cool   = (r_state == SH_COOL);

  assign w_btn    = {btn_d, btn_u, btn_r, btn_l};
  assign w_win    = pick_dir(w_btn);
  assign w_accept = w_in_ready && !gameover_ctrl && (|w_btn) && (r_energy != '0);
  // Timers are zeroed whenever the FSM leaves play (INIT, gameover, bad encoding).
  assign w_clear  = gameover_ctrl || !(w_in_ready || w_in_active || w_in_cool);

  nexys_starship_tick_counter #(.W(HOLD_W)) u_hold (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (w_clear || w_accept),
    .load_val   (w_clear ? '0 : HOLD_W'(SHIELD_TICKS)),
    .tick       (timer_tick && w_in_active),
    .zero_pulse (w_hold_zero)
  );

  nexys_starship_tick_counter #(.W(COOL_W)) u_cool (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (w_clear || w_hold_zero),
    .load_val   (w_clear ? '0 : COOL_W'(COOLDOWN_TICKS)),
    .tick       (timer_tick && w_in_cool),
    .zero_pulse (w_cool_zero)
  );

`ifdef SHIELD_AUTO_RECHARGE_EN
  localparam int RCH_W = $clog2(RECHARGE_TICKS + 1);

  logic [RCH_W-1:0] r_rch_cnt;
  logic             w_rch_count;

  assign w_rch_count = timer_tick && !gameover_ctrl && (w_in_ready || w_in_cool) &&
                       (r_energy < E_MAX);
  assign w_recharge  = w_rch_count && (r_rch_cnt == RCH_W'(RECHARGE_TICKS - 1));

  always_ff @(posedge Clk) begin
    if (Reset || w_clear || w_recharge) r_rch_cnt <= '0;
    else if (w_rch_count)               r_rch_cnt <= r_rch_cnt + RCH_W'(1);
  end
`else
  logic w_unused_recharge;

  assign w_recharge        = 1'b0;
  assign w_unused_recharge = (RECHARGE_TICKS != 0);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= SH_INIT;
      r_shield <= '0;
      r_energy <= E_MAX;
    end else begin
      case (r_state)
        SH_INIT: begin
          r_shield <= '0;
          r_energy <= E_MAX;
          if (play_flag) r_state <= SH_READY;
        end
        SH_READY: begin
          if (gameover_ctrl) begin
            r_state  <= SH_INIT;
            r_shield <= '0;
            r_energy <= E_MAX;
          end else if (w_accept) begin
            r_state  <= SH_ACTIVE;
            r_shield <= w_win;
            // A spend landing on the recharge tick cancels out.
            if (!w_recharge) r_energy <= r_energy - ENERGY_W'(1);
          end else if (w_recharge) begin
            r_energy <= r_energy + ENERGY_W'(1);
          end
        end
        SH_ACTIVE: begin
          if (gameover_ctrl) begin
            r_state  <= SH_INIT;
            r_shield <= '0;
            r_energy <= E_MAX;
          end else if (w_hold_zero) begin
            r_state  <= SH_COOL;
            r_shield <= '0;
          end
        end
        SH_COOL: begin
          if (gameover_ctrl) begin
            r_state  <= SH_INIT;
            r_shield <= '0;
            r_energy <= E_MAX;
          end else begin
            if (w_cool_zero) r_state  <= SH_READY;
            if (w_recharge)  r_energy <= r_energy + ENERGY_W'(1);
          end
        end
        default: begin
          r_state  <= SH_INIT;
          r_shield <= '0;
          r_energy <= E_MAX;
        end
      endcase
    end
  end

  assign left_shield   = r_shield[DIR_L];
  assign right_shield  = r_shield[DIR_R];
  assign top_shield    = r_shield[DIR_U];
  assign btm_shield    = r_shield[DIR_D];
  assign shield_energy = r_energy;
  assign q_SH_Init     = r_state[0];
  assign q_SH_Ready    = r_state[1];
  assign q_SH_Active   = r_state[2];
  assign q_SH_Cool     = r_state[3];

endmodule
